keypad_pin_entry: RTL and testbench
===================================

// Module: keypad_pin_entry
// PURPOSE
//  Consumer stage for the 4x3 keypad decoder. Debounces decoder key codes into single key events.
//  Assembles up to PIN_LEN BCD digits and checks them against a stored PIN on '#'.
//  Emits one-cycle unlock/fail pulses and enforces a timed lockout after repeated failures.
//  Sits between the keypad decoder and the lock actuator / status LEDs.
// PARAMETERS
//  PIN_LEN         4             digits per code, 1..4
//  PIN             16'h1234      expected code, BCD, right-aligned, low PIN_LEN nibbles used
//  DEBOUNCE_CYC    50_000        cycles a press/release must be stable (1 ms @ 50 MHz)
//  MAX_FAILS       3             consecutive wrong codes that trigger lockout, >=1
//  LOCKOUT_CYC     250_000_000   lockout duration in cycles (5 s @ 50 MHz)
// PORTS
//  i_clk        in   1   system clock, all logic on rising edge
//  i_rst        in   1   synchronous, active-high reset
//  i_digit      in   4   decoder key code: 0-9 digits, 10='*', 11='#', 12-15 invalid
//  i_key_valid  in   1   high while decoder sees a key held (level)
//  o_key_stb    out  1   one-cycle pulse per accepted key event
//  o_entry      out  16  entered digits, BCD, newest digit in [3:0], zero-filled
//  o_count      out  3   number of digits entered, 0..PIN_LEN
//  o_unlock     out  1   one-cycle pulse: correct code submitted
//  o_fail       out  1   one-cycle pulse: wrong/short code submitted
//  o_locked     out  1   high during lockout
// BEHAVIOUR
//  Reset: all outputs 0, fail counter 0, debouncer in IDLE, entry FSM in ENTRY.
//  Debouncer FSM: IDLE -> PRESS -> HELD -> RELEASE -> IDLE.
//   IDLE: on i_key_valid=1 latch i_digit, clear counter, go to PRESS.
//   PRESS: if i_key_valid=0, return to IDLE; if i_digit differs from latch, relatch and clear counter.
//    After DEBOUNCE_CYC consecutive stable cycles: o_key_stb=1 for 1 cycle with the latched code, go to HELD.
//   HELD: on i_key_valid=0 clear counter, go to RELEASE. No repeat events while held.
//   RELEASE: after DEBOUNCE_CYC consecutive cycles of i_key_valid=0, go to IDLE.
//    Any i_key_valid=1 returns to HELD.
//  Entry FSM: ENTRY, LOCKOUT. Acts in the cycle after o_key_stb (1-cycle latency).
//   ENTRY, digit 0-9:
//    If o_count<PIN_LEN: o_entry <= {o_entry[11:0],digit}, o_count+1.
//    If o_count==PIN_LEN: the digit is ignored.
//   ENTRY, '*': o_entry=0, o_count=0. Fail counter unchanged.
//   ENTRY, '#' with o_count==PIN_LEN and entry matching PIN[4*PIN_LEN-1:0]:
//    o_unlock pulse, fail counter cleared.
//   ENTRY, '#' otherwise (including o_count<PIN_LEN): o_fail pulse, fail counter +1.
//    If the counter reaches MAX_FAILS: go to LOCKOUT and load the timer.
//   After either '#' outcome: o_entry=0, o_count=0 in the same cycle as the pulse.
//   Codes 12-15: ignored, no state change.
//   LOCKOUT: o_locked=1, timer counts down from LOCKOUT_CYC-1.
//    All key events are discarded; the debouncer keeps running.
//    At 0: go to ENTRY, o_locked=0, fail counter cleared.
//   A strobe coinciding with lockout expiry is discarded.
//  Width rules: counters sized with $clog2 of their parameter. Fail counter saturates at MAX_FAILS.
//  o_unlock and o_fail are never high together.
//  Reset mid-press or mid-lockout: immediate return to reset state. No pending event survives.
// STRUCTURE
//  Package keypad_pkg: KEY_STAR=4'd10, KEY_HASH=4'd11, key-code width, debouncer and entry FSM state encodings.
//  Sub-module key_event_debounce (i_clk, i_rst, i_digit, i_key_valid -> o_stb, o_code).
//   Shareable with other keypad consumers.
//  Top holds the entry shift register, comparator, fail counter and lockout timer.
// TESTING  (bench overrides DEBOUNCE_CYC=4, LOCKOUT_CYC=20, MAX_FAILS=3, PIN=16'h1234)
//  Press '5' stable 4 cycles then release -> exactly one o_key_stb.
//   Next cycle: o_entry=16'h0005, o_count=1.
//  Glitch i_key_valid high 2 cycles only -> no strobe, entry unchanged.
//  Code changes 3->7 mid-PRESS -> one strobe, code 7.
//  Keys 1,2,3,4,'#' -> o_unlock=1 for 1 cycle, o_fail=0, o_entry=0, o_count=0.
//  Keys 1,2,3,4,5 -> o_entry=16'h1234, o_count=4 (fifth digit ignored).
//   Then '*' -> o_entry=0, o_count=0.
//  Three '#' with wrong codes 9,9,9,9 -> three o_fail pulses, o_locked=1 for exactly 20 cycles.
//   Keys 1,2,3,4,'#' pressed during lockout -> no effect.
//   After expiry, keys 1,2,3,4,'#' -> o_unlock.
//  Assert i_rst during lockout and during a held key -> all outputs 0 next cycle.
//   No strobe on release of the held key.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared key codes and FSM state encodings for the keypad consumer blocks.
package keypad_pkg;

    localparam int KEY_W = 4;
    localparam logic [KEY_W-1:0] KEY_STAR = 4'd10;
    localparam logic [KEY_W-1:0] KEY_HASH = 4'd11;

    typedef enum logic [1:0] {
        DB_IDLE,
        DB_PRESS,
        DB_HELD,
        DB_RELEASE
    } db_state_e;

    typedef enum logic {
        ST_ENTRY,
        ST_LOCKOUT
    } entry_state_e;

    function automatic logic is_digit(input logic [KEY_W-1:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/key_event_debounce.sv
// Turns a held-level key code into exactly one strobe per debounced press.
module key_event_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 50_000
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [KEY_W-1:0] i_digit,
    input  logic             i_key_valid,
    output logic             o_stb,
    output logic [KEY_W-1:0] o_code
);

    localparam int DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

    db_state_e        state_q, state_d;
    logic [DB_W-1:0]  cnt_q, cnt_d;
    logic [KEY_W-1:0] code_q, code_d;
    logic             stb_q, stb_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= DB_IDLE;
            cnt_q   <= '0;
            code_q  <= '0;
            stb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            stb_q   <= stb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        stb_d   = 1'b0;
        case (state_q)
            DB_IDLE: begin
                if (i_key_valid) begin
                    code_d  = i_digit;
                    cnt_d   = '0;
                    state_d = DB_PRESS;
                end
            end
            DB_PRESS: begin
                // A changed code restarts the stability window on the new code.
                if (!i_key_valid) begin
                    state_d = DB_IDLE;
                end else if (i_digit != code_q) begin
                    code_d = i_digit;
                    cnt_d  = '0;
                end else if (cnt_q == DB_LAST) begin
                    stb_d   = 1'b1;
                    state_d = DB_HELD;
                end else begin
                    cnt_d = cnt_q + DB_W'(1);
                end
            end
            DB_HELD: begin
                if (!i_key_valid) begin
                    cnt_d   = '0;
                    state_d = DB_RELEASE;
                end
            end
            DB_RELEASE: begin
                if (i_key_valid) begin
                    state_d = DB_HELD;
                end else if (cnt_q == DB_LAST) begin
                    state_d = DB_IDLE;
                end else begin
                    cnt_d = cnt_q + DB_W'(1);
                end
            end
            default: state_d = DB_IDLE;
        endcase
    end

    assign o_stb  = stb_q;
    assign o_code = code_q;

endmodule

// File: rtl/keypad_pin_entry.sv
// PIN entry: debounced keys build a BCD code, '#' checks it, repeated
// failures trigger a timed lockout.
module keypad_pin_entry
    import keypad_pkg::*;
#(
    parameter int          PIN_LEN      = 4,
    parameter logic [15:0] PIN          = 16'h1234,
    parameter int          DEBOUNCE_CYC = 50_000,
    parameter int          MAX_FAILS    = 3,
    parameter int          LOCKOUT_CYC  = 250_000_000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [3:0]  i_digit,
    input  logic        i_key_valid,
    output logic        o_key_stb,
    output logic [15:0] o_entry,
    output logic [2:0]  o_count,
    output logic        o_unlock,
    output logic        o_fail,
    output logic        o_locked
);

    localparam int FC_W = $clog2(MAX_FAILS + 1);
    localparam int LT_W = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;
    localparam logic [FC_W-1:0] FAIL_LAST = FC_W'(MAX_FAILS - 1);
    localparam logic [FC_W-1:0] FAIL_MAX  = FC_W'(MAX_FAILS);
    localparam logic [LT_W-1:0] LOCK_LAST = LT_W'(LOCKOUT_CYC - 1);
    localparam logic [2:0]      LEN_C     = 3'(PIN_LEN);
    localparam logic [15:0]     PIN_MASK  = 16'((32'h1 << (4 * PIN_LEN)) - 1);

    logic             key_stb;
    logic [KEY_W-1:0] key_code;

    key_event_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_debounce (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_digit    (i_digit),
        .i_key_valid(i_key_valid),
        .o_stb      (key_stb),
        .o_code     (key_code)
    );

    entry_state_e    state_q, state_d;
    logic [15:0]     entry_q, entry_d;
    logic [2:0]      count_q, count_d;
    logic [FC_W-1:0] fails_q, fails_d;
    logic [LT_W-1:0] timer_q, timer_d;
    logic            unlock_q, unlock_d;
    logic            fail_q, fail_d;
    logic            match;

    assign match = (count_q == LEN_C) && ((entry_q & PIN_MASK) == (PIN & PIN_MASK));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_ENTRY;
            entry_q  <= '0;
            count_q  <= '0;
            fails_q  <= '0;
            timer_q  <= '0;
            unlock_q <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            entry_q  <= entry_d;
            count_q  <= count_d;
            fails_q  <= fails_d;
            timer_q  <= timer_d;
            unlock_q <= unlock_d;
            fail_q   <= fail_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        entry_d  = entry_q;
        count_d  = count_q;
        fails_d  = fails_q;
        timer_d  = timer_q;
        unlock_d = 1'b0;
        fail_d   = 1'b0;
        case (state_q)
            ST_ENTRY: begin
                if (key_stb) begin
                    if (is_digit(key_code)) begin
                        if (count_q < LEN_C) begin
                            entry_d = {entry_q[11:0], key_code};
                            count_d = count_q + 3'd1;
                        end
                    end else if (key_code == KEY_STAR) begin
                        entry_d = '0;
                        count_d = '0;
                    end else if (key_code == KEY_HASH) begin
                        entry_d = '0;
                        count_d = '0;
                        if (match) begin
                            unlock_d = 1'b1;
                            fails_d  = '0;
                        end else begin
                            fail_d = 1'b1;
                            if (fails_q >= FAIL_LAST) begin
                                fails_d = FAIL_MAX;
                                timer_d = LOCK_LAST;
                                state_d = ST_LOCKOUT;
                            end else begin
                                fails_d = fails_q + FC_W'(1);
                            end
                        end
                    end
                end
            end
            ST_LOCKOUT: begin
                // Strobes here, including one on the expiry cycle, are dropped.
                if (timer_q == '0) begin
                    state_d = ST_ENTRY;
                    fails_d = '0;
                end else begin
                    timer_d = timer_q - LT_W'(1);
                end
            end
            default: state_d = ST_ENTRY;
        endcase
    end

    assign o_key_stb = key_stb;
    assign o_entry   = entry_q;
    assign o_count   = count_q;
    assign o_unlock  = unlock_q;
    assign o_fail    = fail_q;
    assign o_locked  = (state_q == ST_LOCKOUT);

endmodule

// File: tb/tb_keypad_pin_entry.sv
// Bench for keypad_pin_entry: directed scenarios plus random key streams
// checked against a digit-queue model of the PIN entry rules.
module tb_keypad_pin_entry;

    localparam int          PIN_LEN = 4;
    localparam logic [15:0] PIN     = 16'h1234;
    localparam int          DB      = 4;
    localparam int          MAXF    = 3;
    localparam int          LOCK    = 20;
    localparam int          HOLD    = 7;
    localparam int          GAP     = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  digit = '0;
    logic        valid = 1'b0;
    logic        key_stb, unlock, fail, locked;
    logic [15:0] entry;
    logic [2:0]  count;

    keypad_pin_entry #(
        .PIN_LEN(PIN_LEN), .PIN(PIN), .DEBOUNCE_CYC(DB),
        .MAX_FAILS(MAXF), .LOCKOUT_CYC(LOCK)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_digit(digit), .i_key_valid(valid),
        .o_key_stb(key_stb), .o_entry(entry), .o_count(count),
        .o_unlock(unlock), .o_fail(fail), .o_locked(locked)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    // Event counters observed just after each rising edge.
    int stb_cnt = 0, unlock_cnt = 0, fail_cnt = 0, both_cnt = 0, dirty_cnt = 0;
    int run = 0, last_run = 0, lock_bad = 0;
    logic        stb_prev = 1'b0, locked_prev = 1'b0;
    logic [15:0] post_stb_entry = '0;

    always @(posedge clk) begin
        #1;
        stb_cnt    += int'(key_stb);
        unlock_cnt += int'(unlock);
        fail_cnt   += int'(fail);
        if (unlock && fail) both_cnt++;
        if ((unlock || fail) && (entry != 0 || count != 0)) dirty_cnt++;
        if (locked && !locked_prev && !fail) lock_bad++;
        if (stb_prev) post_stb_entry = entry;
        stb_prev    = key_stb;
        locked_prev = locked;
        if (locked) run++;
        else if (run != 0) begin
            last_run = run;
            run = 0;
        end
    end

    int errors = 0, checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: digits as a queue, plain counters for outcomes.
    int mq[$];
    int mfails = 0, exp_stb = 0, exp_unlock = 0, exp_fail = 0;
    bit mlocked = 0;

    function automatic int pin_digit(input int i);
        return int'((PIN >> (4 * (PIN_LEN - 1 - i))) & 16'hF);
    endfunction

    function automatic int m_entry();
        int e = 0;
        foreach (mq[i]) e = e * 16 + mq[i];
        return e;
    endfunction

    task automatic model_key(input int code);
        bit ok;
        exp_stb++;
        if (code <= 9) begin
            if (mq.size() < PIN_LEN) mq.push_back(code);
        end else if (code == 10) begin
            mq.delete();
        end else if (code == 11) begin
            ok = (mq.size() == PIN_LEN);
            if (ok) for (int i = 0; i < PIN_LEN; i++) if (mq[i] != pin_digit(i)) ok = 0;
            if (ok) begin
                exp_unlock++;
                mfails = 0;
            end else begin
                exp_fail++;
                mfails++;
                if (mfails >= MAXF) mlocked = 1;
            end
            mq.delete();
        end
    endtask

    task automatic drive(input logic [3:0] code, input int hold, input int gap);
        @(negedge clk);
        digit = code;
        valid = 1'b1;
        repeat (hold - 1) @(negedge clk);
        valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".entry"},  32'(entry),      32'(m_entry()));
        chk({tag, ".count"},  32'(count),      32'(mq.size()));
        chk({tag, ".stb"},    32'(stb_cnt),    32'(exp_stb));
        chk({tag, ".unlock"}, 32'(unlock_cnt), 32'(exp_unlock));
        chk({tag, ".fail"},   32'(fail_cnt),   32'(exp_fail));
    endtask

    task automatic key(input int code, input string tag);
        drive(4'(code), HOLD, GAP);
        model_key(code);
        check_state(tag);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".stb"},    32'(key_stb), 0);
        chk({tag, ".entry"},  32'(entry),   0);
        chk({tag, ".count"},  32'(count),   0);
        chk({tag, ".unlock"}, 32'(unlock),  0);
        chk({tag, ".fail"},   32'(fail),    0);
        chk({tag, ".locked"}, 32'(locked),  0);
    endtask

    task automatic model_reset();
        mq.delete();
        mfails  = 0;
        mlocked = 0;
    endtask

    initial begin
        int n, c;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        key(5, "press5");
        chk("press5.latency", 32'(post_stb_entry), 32'h0005);

        drive(4'd8, 2, GAP);
        check_state("glitch");

        // Code change mid-press: one strobe carrying the final code.
        key(10, "clr0");
        @(negedge clk);
        digit = 4'd3;
        valid = 1'b1;
        repeat (2) @(negedge clk);
        digit = 4'd7;
        repeat (HOLD) @(negedge clk);
        valid = 1'b0;
        repeat (GAP) @(negedge clk);
        model_key(7);
        check_state("change3to7");
        key(10, "clr1");

        for (int i = 0; i < PIN_LEN; i++) key(pin_digit(i), "good");
        key(11, "good_hash");

        for (int i = 1; i <= 5; i++) key(i, "five");
        chk("five.entry_val", 32'(entry), 32'h1234);
        key(10, "five_star");

        for (int f = 0; f < MAXF; f++) begin
            for (int i = 0; i < PIN_LEN; i++) key(9, "wrong");
            key(11, "wrong_hash");
        end
        chk("lock.active", 32'(locked), 1);
        drive(4'd1, HOLD, GAP);
        exp_stb++;
        repeat (5) @(negedge clk);
        model_reset();
        check_state("lock.discard");
        chk("lock.released", 32'(locked), 0);
        chk("lock.duration", 32'(last_run), LOCK);
        chk("lock.with_fail", 32'(lock_bad), 0);
        for (int i = 0; i < PIN_LEN; i++) key(pin_digit(i), "post_lock");
        key(11, "post_lock_hash");

        // Reset in the middle of a lockout.
        for (int f = 0; f < MAXF; f++) key(11, "short_hash");
        chk("rstlock.active", 32'(locked), 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_zero("rstlock");
        rst = 1'b0;
        model_reset();
        key(11, "rstlock.hash");
        chk("rstlock.not_locked", 32'(locked), 0);

        // Reset while a key is held: its release must not strobe.
        key(5, "held_pre");
        @(negedge clk);
        digit = 4'd6;
        valid = 1'b1;
        repeat (HOLD + 2) @(negedge clk);
        model_key(6);
        check_state("held");
        rst = 1'b1;
        @(negedge clk);
        check_zero("rstheld");
        rst = 1'b0;
        valid = 1'b0;
        model_reset();
        repeat (GAP + 4) @(negedge clk);
        check_state("rstheld.release");

        for (int it = 0; it < 12; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < PIN_LEN; i++) begin
                    drive(4'(pin_digit(i)), $urandom_range(6, 9), $urandom_range(6, 9));
                    model_key(pin_digit(i));
                    check_state("rnd_pin");
                end
            end else begin
                n = $urandom_range(1, 6);
                for (int i = 0; i < n; i++) begin
                    if ($urandom_range(0, 4) == 0) begin
                        drive(4'($urandom_range(0, 15)), $urandom_range(1, 3), GAP);
                        check_state("rnd_glitch");
                    end
                    c = $urandom_range(0, 15);
                    if (c == 11) c = 12;
                    drive(4'(c), $urandom_range(6, 9), $urandom_range(6, 9));
                    model_key(c);
                    check_state("rnd_key");
                end
            end
            drive(4'd11, HOLD, GAP);
            model_key(11);
            check_state("rnd_hash");
            if (mlocked) begin
                chk("rnd.locked", 32'(locked), 1);
                repeat (LOCK + 2) @(negedge clk);
                chk("rnd.unlocked", 32'(locked), 0);
                mlocked = 0;
                mfails  = 0;
            end
        end

        chk("never_both", 32'(both_cnt), 0);
        chk("pulse_clears_entry", 32'(dirty_cnt), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
